// File: rtl/wdt_pkg.sv
// Shared constants, state encoding and decode helper for the watchdog.
// Build option: WDT_PRESCALE_EN enables the WDPRE register and tick prescaler.
package wdt_pkg;

  localparam logic [4:0] WDEN_ADDR   = 5'h00;
  localparam logic [4:0] WDLIVE_ADDR = 5'h04;
  localparam logic [4:0] WTOCNT_ADDR = 5'h08;
  localparam logic [4:0] WDSTAT_ADDR = 5'h0C;
  localparam logic [4:0] WDPRE_ADDR  = 5'h10;

  localparam int WDEN_EN_BIT      = 0;
  localparam int WDLIVE_KICK_BIT  = 0;
  localparam int WDSTAT_FIRED_BIT = 0;
  localparam int WDSTAT_RUN_BIT   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } wdt_state_e;

  function automatic logic wr_hit(
    input logic       en,
    input logic [4:0] addr,
    input logic [4:0] match
  );
    return en && (addr == match);
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Tick prescaler: pulses tick once every pre+1 enabled cycles.
// Only compiled when WDT_PRESCALE_EN is defined.
`ifdef WDT_PRESCALE_EN
module wdt_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  // >= keeps the period sane if pre is lowered mid-count
  assign tick = en && (cnt_q >= pre);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/wdt_timer.sv
// Watchdog timer with register port; drives timeout for HOLD cycles on expiry.
// Build option: WDT_PRESCALE_EN adds WDPRE and the wdt_prescaler tick source.
module wdt_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  parameter int HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        timeout
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD - 1);

  wdt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              wden_q, wden_d;
  logic [CNT_W-1:0]  wtocnt_q, wtocnt_d;
  logic              fired_q, fired_d;
  logic              fired_set;

  logic wr_wden, wr_live, wr_tocnt, wr_stat;
  logic arm, disarm, kick, fired_clr;
  logic tick;
  logic running;

  assign wr_wden  = wr_hit(wr_en, wr_addr, WDEN_ADDR);
  assign wr_live  = wr_hit(wr_en, wr_addr, WDLIVE_ADDR);
  assign wr_tocnt = wr_hit(wr_en, wr_addr, WTOCNT_ADDR);
  assign wr_stat  = wr_hit(wr_en, wr_addr, WDSTAT_ADDR);

  assign arm       = wr_wden && wr_data[WDEN_EN_BIT];
  assign disarm    = wr_wden && !wr_data[WDEN_EN_BIT];
  assign kick      = wr_live && wr_data[WDLIVE_KICK_BIT];
  assign fired_clr = wr_stat && wr_data[WDSTAT_FIRED_BIT];

  assign running = (state_q != IDLE);
  assign timeout = timeout_q;

`ifdef WDT_PRESCALE_EN
  logic [PRE_W-1:0] wdpre_q, wdpre_d;
  logic             wr_pre;
  logic             pre_clr;
  logic             pre_en;

  assign wr_pre = wr_hit(wr_en, wr_addr, WDPRE_ADDR);
  assign pre_en = (state_q == COUNT);

  // Restart the tick phase whenever cnt is (re)loaded
  assign pre_clr = disarm
                || ((state_q == IDLE) && arm)
                || ((state_q == COUNT) && kick)
                || ((state_q == FIRE) && (hold_q == '0));

  always_comb begin
    wdpre_d = wdpre_q;
    if (wr_pre) wdpre_d = PRE_W'(wr_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdpre_q <= '0;
    end else begin
      wdpre_q <= wdpre_d;
    end
  end

  wdt_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .pre  (wdpre_q),
    .tick (tick)
  );
`else
  logic [PRE_W-1:0] wdpre_q;

  assign wdpre_q = '0;
  assign tick    = 1'b1;
`endif

  always_comb begin
    wden_d   = wden_q;
    wtocnt_d = wtocnt_q;
    if (wr_wden)  wden_d   = wr_data[WDEN_EN_BIT];
    if (wr_tocnt) wtocnt_d = CNT_W'(wr_data);
  end

  // Hardware set beats a same-cycle software clear
  assign fired_d = (fired_q && !fired_clr) || fired_set;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    fired_set = 1'b0;
    if (disarm) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hold_d    = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d     = '0;
          timeout_d = 1'b0;
          if (arm) begin
            state_d = COUNT;
            cnt_d   = wtocnt_q;
          end
        end
        COUNT: begin
          if (kick) begin
            cnt_d = wtocnt_q;
          end else if (tick) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              state_d   = FIRE;
              timeout_d = 1'b1;
              hold_d    = HOLD_LD;
              fired_set = 1'b1;
            end
          end
        end
        FIRE: begin
          if (hold_q == '0) begin
            timeout_d = 1'b0;
            if (wden_q) begin
              state_d = COUNT;
              cnt_d   = wtocnt_q;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          hold_d    = '0;
          timeout_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      wden_q    <= 1'b0;
      wtocnt_q  <= '0;
      fired_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      wden_q    <= wden_d;
      wtocnt_q  <= wtocnt_d;
      fired_q   <= fired_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (rd_addr == WDEN_ADDR):   rd_data[WDEN_EN_BIT] = wden_q;
      (rd_addr == WTOCNT_ADDR): rd_data = 32'(wtocnt_q);
      (rd_addr == WDSTAT_ADDR): begin
        rd_data[WDSTAT_FIRED_BIT] = fired_q;
        rd_data[WDSTAT_RUN_BIT]   = running;
      end
      (rd_addr == WDPRE_ADDR):  rd_data = 32'(wdpre_q);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_wdt_timer.sv
// Directed bench for wdt_timer: expiry timing, kicks, disarm, fired flag.
// Prescale expectations follow WDT_PRESCALE_EN.
module tb_wdt_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] A_WDEN = 5'h00;
  localparam logic [4:0] A_LIVE = 5'h04;
  localparam logic [4:0] A_TOCNT = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;
  localparam logic [4:0] A_PRE = 5'h10;

`ifdef WDT_PRESCALE_EN
  localparam int PRE_RD = 3;
  localparam int PRE_LAT = 12;
  localparam int UNM_PRE = 5;
`else
  localparam int PRE_RD = 0;
  localparam int PRE_LAT = 3;
  localparam int UNM_PRE = 0;
`endif

  wdt_timer #(
    .CNT_W (32),
    .PRE_W (8),
    .HOLD  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic disarm_clear();
    wr(A_WDEN, 32'h0);
    wr(A_STAT, 32'h1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    step(2);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout: got %0b want 0", timeout);
    end
    rst = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      rd(5'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd[%0h]: got %0h want 0", i * 4, d);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h01, 32'h1);
    wr(A_PRE, 32'h5);
    rd(5'h14, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_rd: got %0h want 0", d);
    end
    rd(A_WDEN, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL unaligned_wr: WDEN got %0h want 0", d);
    end
    rd(A_PRE, d);
    checks++;
    if (d !== 32'(UNM_PRE)) begin
      failures++;
      $display("FAIL wdpre_rw: got %0h want %0h", d, UNM_PRE);
    end
    wr(A_PRE, 32'h0);
  endtask

  task automatic test_expiry();
    logic [31:0] d;
    wr(A_TOCNT, 32'd5);
    rd(A_TOCNT, d);
    checks++;
    if (d !== 32'd5) begin
      failures++;
      $display("FAIL wtocnt_rd: got %0h want 5", d);
    end
    wr(A_WDEN, 32'h1);
    step(5);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL exp_e5: timeout got %0b want 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL exp_e6: timeout got %0b want 1", timeout);
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL exp_stat: got %0h want 3", d);
    end
    step(3);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL exp_e9: timeout got %0b want 1", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL exp_e10: timeout got %0b want 0", timeout);
    end
    step(5);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL exp_e15: timeout got %0b want 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL exp_e16: timeout got %0b want 1", timeout);
    end
  endtask

  task automatic test_disarm_in_fire();
    logic [31:0] d;
    int highs = 0;
    wr(A_WDEN, 32'h0);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL disarm_timeout: got %0b want 0", timeout);
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL disarm_stat: got %0h want 1", d);
    end
    wr(A_STAT, 32'h1);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL fired_clr: got %0h want 0", d);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (timeout === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL idle_quiet: highs got %0d want 0", highs);
    end
  endtask

  task automatic test_kick();
    int highs = 0;
    wr(A_TOCNT, 32'd5);
    wr(A_WDEN, 32'h1);
    step(5);
    wr(A_LIVE, 32'h1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL kick_wins: timeout got %0b want 0", timeout);
    end
    step(5);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL kick_k5: timeout got %0b want 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL kick_k6: timeout got %0b want 1", timeout);
    end
    disarm_clear();
    wr(A_WDEN, 32'h1);
    step(4);
    wr(A_LIVE, 32'h0);
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL kick_bit0_zero: timeout got %0b want 1", timeout);
    end
    disarm_clear();
    wr(A_WDEN, 32'h1);
    for (int i = 0; i < 25; i++) begin
      wr(A_LIVE, 32'h1);
      if (timeout === 1'b1) highs++;
      for (int j = 0; j < 3; j++) begin
        step(1);
        if (timeout === 1'b1) highs++;
      end
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL kick_stream: highs got %0d want 0", highs);
    end
    disarm_clear();
  endtask

  task automatic test_wtocnt_live();
    wr(A_TOCNT, 32'd5);
    wr(A_WDEN, 32'h1);
    step(1);
    wr(A_TOCNT, 32'd1);
    step(3);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL live_e5: timeout got %0b want 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL live_e6: timeout got %0b want 1", timeout);
    end
    step(5);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL live_e11: timeout got %0b want 0", timeout);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL live_e12: timeout got %0b want 1", timeout);
    end
    disarm_clear();
  endtask

  task automatic test_zero_and_set_wins();
    logic [31:0] d;
    wr(A_TOCNT, 32'd0);
    wr(A_WDEN, 32'h1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL zero_e0: timeout got %0b want 0", timeout);
    end
    wr(A_STAT, 32'h1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL zero_e1: timeout got %0b want 1", timeout);
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL set_beats_clr: got %0h want 3", d);
    end
    disarm_clear();
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    int lat = -1;
    wr(A_PRE, 32'd3);
    rd(A_PRE, d);
    checks++;
    if (d !== 32'(PRE_RD)) begin
      failures++;
      $display("FAIL pre_rd: got %0h want %0h", d, PRE_RD);
    end
    wr(A_TOCNT, 32'd2);
    wr(A_WDEN, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (timeout === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== PRE_LAT) begin
      failures++;
      $display("FAIL pre_latency: got %0d want %0d", lat, PRE_LAT);
    end
    disarm_clear();
    wr(A_PRE, 32'h0);
  endtask

  task automatic test_reset_mid_fire();
    logic [31:0] d;
    wr(A_TOCNT, 32'd0);
    wr(A_WDEN, 32'h1);
    step(1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL mid_fire_pre: timeout got %0b want 1", timeout);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: timeout got %0b want 0", timeout);
    end
    step(1);
    rst = 1'b1;
    rd(A_WDEN, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_wden: got %0h want 0", d);
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_stat: got %0h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_expiry();
    test_disarm_in_fire();
    test_kick();
    test_wtocnt_live();
    test_zero_and_set_wins();
    test_prescale();
    test_reset_mid_fire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wdt_timer.md
# wdt_timer

Watchdog timer that produces the `timeout` signal consumed by the CPU's CSR unit as both the timer interrupt and the system reset request. Software arms it through a small register port, kicks it periodically, and, if a kick is missed, the block drives `timeout` high for a fixed number of cycles. It sits on the peripheral bus next to the DMA, which is the other interrupt source.

## Interface
- `CNT_W`, default 32: width of the timeout counter and of WTOCNT.
- `PRE_W`, default 8: width of the prescaler register (used only with the macro).
- `HOLD`, default 4: number of cycles `timeout` stays high per expiry, minimum 1.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: register write strobe, single-cycle, always accepted.
- `wr_addr` in 5: byte address of the write, word-aligned.
- `wr_data` in 32: write data.
- `rd_addr` in 5: read address.
- `rd_data` out 32: combinational read data.
- `timeout` out 1: registered watchdog expiry, high for HOLD cycles.

## Operation
- Register map:
  - 0x00 WDEN: bit0 is the enable.
  - 0x04 WDLIVE: writing bit0=1 kicks the watchdog. Reads return 0.
  - 0x08 WTOCNT: reload value, CNT_W bits.
  - 0x0C WDSTAT: bit0 is a sticky `fired` flag, cleared by writing 1 to it. bit1 is `running`, read-only (state ≠ IDLE).
  - 0x10 WDPRE: see Configuration.
  - Unmapped addresses read 0; writes to them are ignored.
- State machine:
  - IDLE:
    - `cnt` = 0 and `timeout` = 0.
    - A WDEN write with bit0=1 loads `cnt` with WTOCNT and moves to COUNT.
  - COUNT:
    - On each `tick`, a kick reloads `cnt` from WTOCNT.
    - Otherwise, if `cnt` ≠ 0, it decrements.
    - Otherwise (`cnt` = 0), the block moves to FIRE: `timeout` goes to 1, `hold` is loaded with HOLD-1, and `fired` is set.
    - A kick reloads `cnt` even without a `tick`.
  - FIRE:
    - `timeout` = 1. Kicks are ignored.
    - When `hold` = 0, `timeout` drops. The block goes to COUNT with `cnt` reloaded from WTOCNT if WDEN=1, else to IDLE.
- A WDEN write with bit0=0 in any state moves to IDLE at the next edge and clears `timeout`.
- A WTOCNT write while counting does not touch `cnt`; it takes effect at the next reload.
- Kick and expiry in the same cycle: the kick wins and no FIRE occurs.
- Same-cycle ordering for `fired`: hardware set beats software clear.
- WTOCNT=0: expiry occurs on the first `tick` after arming.
- The counter never wraps: decrement is gated at 0.

## Timing
- Reset values:
  - State IDLE; `cnt`, `hold`, prescaler all 0.
  - WDEN=0, WTOCNT=0, WDPRE=0, `fired`=0.
  - `timeout`=0.
  - `rd_data` reflects the reset registers.
- Register writes take effect at the edge where `wr_en`=1. `rd_data` shows the new value in the following cycle.
- Expiry latency, no prescale, no kicks: with the WDEN write at edge E0 and WTOCNT=N, `timeout` rises at edge E0+N+1 and falls at E0+N+1+HOLD.
- Kick latency: a kick at edge K postpones expiry to K+WTOCNT+1.
- Reset asserted mid-FIRE drops `timeout` asynchronously.

## Configuration
- `WDT_PRESCALE_EN` defined:
  - WDPRE (PRE_W bits) is read/write.
  - `tick` pulses once every WDPRE+1 cycles.
  - The prescaler counter clears on arming, on every kick, and on FIRE exit.
  - Expiry latency becomes (N+1)·(WDPRE+1) cycles after arming.
- Not defined:
  - `tick` is constant 1.
  - WDPRE reads 0 and writes to it are ignored.
  - No prescaler logic is instantiated.

## Structure
- Package `wdt_pkg`:
  - Register address constants (WDEN_ADDR, WDLIVE_ADDR, WTOCNT_ADDR, WDSTAT_ADDR, WDPRE_ADDR).
  - State enum `wdt_state_e` {IDLE, COUNT, FIRE}.
  - WDSTAT bit index constants.
- Sub-module `wdt_prescaler`: counter plus compare, producing `tick`. Instantiated only under `WDT_PRESCALE_EN`.

## Test plan
- Reset, then read all registers → all 0, `timeout`=0, `running`=0.
- WTOCNT=5, WDEN=1 at E0, no kicks → `timeout` high from E6 through E9 (HOLD=4), WDSTAT=0b11, then re-armed so the next rise is at E16.
- WTOCNT=5, kick on the same edge `cnt` reaches 0 → no expiry. Continuous kicks every 4 cycles → `timeout` never rises over 100 cycles.
- WTOCNT=0, arm → `timeout` rises exactly 1 cycle after arming.
- During FIRE write WDEN=0 → `timeout` 0 next cycle, state IDLE. Write WDSTAT=1 → `fired`=0.
- With `WDT_PRESCALE_EN`, WDPRE=3, WTOCNT=2 → `timeout` rises 12 cycles after arming. Without the macro, same stimulus → 3 cycles.
